// File: rtl/dma_rd_engine_if.sv
// rtl/dma_rd_engine_if.sv - peripheral, memory-port and FIFO-drain signals of the DMA read channel
// master = peripheral/memory side driving go, responses and pops; slave = dma_rd_engine.
interface dma_rd_engine_if #(
  parameter int ADDR_WIDTH = 42,
  parameter int DATA_WIDTH = 512
);
  logic                  go;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH:0]   size;
  logic                  done;
  logic                  mem_req_valid;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_req_almost_full;
  logic                  mem_rsp_valid;
  logic [DATA_WIDTH-1:0] mem_rsp_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;

  modport master (
    output go, start_addr, size, mem_req_almost_full, mem_rsp_valid, mem_rsp_data, rd_en,
    input  done, mem_req_valid, mem_req_addr, rd_data, empty
  );

  modport slave (
    input  go, start_addr, size, mem_req_almost_full, mem_rsp_valid, mem_rsp_data, rd_en,
    output done, mem_req_valid, mem_req_addr, rd_data, empty
  );
endinterface

// File: rtl/dma_rd_engine.sv
// rtl/dma_rd_engine.sv - DMA read engine: cache-line request generator with credit-limited FWFT response FIFO
// One go produces size contiguous line reads; responses are buffered in order and drained via rd_en.
module dma_rd_engine #(
  parameter int ADDR_WIDTH = 42,
  parameter int DATA_WIDTH = 512,
  parameter int FIFO_DEPTH = 512
) (
  input logic           clk,
  input logic           rst,
  dma_rd_engine_if.slave bus
);
  localparam int CW  = ADDR_WIDTH + 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int FCW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [CW-1:0]         r_size;
  logic [CW-1:0]         r_req_cnt;
  logic [CW-1:0]         r_rsp_cnt;
  logic                  r_done;
  logic                  r_req_valid;
  logic [ADDR_WIDTH-1:0] r_req_addr;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [FCW-1:0]        r_count;

  logic          w_start;
  logic          w_active;
  logic          w_full;
  logic          w_empty;
  logic          w_wr;
  logic          w_rd;
  logic [CW-1:0] w_outstanding;
  logic          w_credit;
  logic          w_last_req;
  logic          w_last_rsp;
  logic          w_issue;
  logic          w_done_nxt;

  assign w_start  = bus.go && (r_state == S_IDLE || r_state == S_DONE);
  assign w_active = (r_state == S_REQ) || (r_state == S_WAIT);
  assign w_full   = (r_count == FCW'(FIFO_DEPTH));
  assign w_empty  = (r_count == '0);
  // Responses outside an active transfer are stale and never enter the FIFO.
  assign w_wr     = bus.mem_rsp_valid && w_active && !w_full;
  assign w_rd     = bus.rd_en && !w_empty;

  // req_cnt counts decisions, so the registered request still in flight is already included here.
  assign w_outstanding = r_req_cnt - r_rsp_cnt;
  assign w_credit      = (w_outstanding + CW'(r_count)) < CW'(FIFO_DEPTH);
  assign w_last_req    = (r_req_cnt == r_size - CW'(1));
  assign w_last_rsp    = w_wr && (r_rsp_cnt + CW'(1) == r_size);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.go) begin
          w_next = (bus.size != '0) ? S_REQ : S_DONE;
        end
      end
      S_REQ: begin
        if (w_issue && w_last_req) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_last_rsp) begin
          w_next = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_issue    = 1'b0;
    w_done_nxt = 1'b0;
    case (r_state)
      S_REQ:   w_issue    = !bus.mem_req_almost_full && w_credit;
      S_DONE:  w_done_nxt = !bus.go;
      default: begin
        w_issue    = 1'b0;
        w_done_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_base      <= '0;
      r_size      <= '0;
      r_req_cnt   <= '0;
      r_rsp_cnt   <= '0;
      r_done      <= 1'b0;
      r_req_valid <= 1'b0;
      r_req_addr  <= '0;
    end else begin
      r_done      <= w_done_nxt;
      r_req_valid <= w_issue;
      if (w_start) begin
        r_base    <= bus.start_addr;
        r_size    <= bus.size;
        r_req_cnt <= '0;
        r_rsp_cnt <= '0;
      end else begin
        if (w_issue) begin
          r_req_addr <= r_base + r_req_cnt[ADDR_WIDTH-1:0];
          r_req_cnt  <= r_req_cnt + CW'(1);
        end
        if (w_wr) begin
          r_rsp_cnt <= r_rsp_cnt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + FCW'(1);
        2'b01:   r_count <= r_count - FCW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= bus.mem_rsp_data;
    end
  end

  assign bus.done          = r_done;
  assign bus.mem_req_valid = r_req_valid;
  assign bus.mem_req_addr  = r_req_addr;
  assign bus.rd_data       = r_mem[r_rd_ptr];
  assign bus.empty         = w_empty;

  // The credit rule makes this unreachable with a compliant memory port.
  a_rsp_into_full: assert property (@(posedge clk) disable iff (!rst)
    !(bus.mem_rsp_valid && w_active && w_full));
endmodule

// File: tb/tb_dma_rd_engine.sv
// tb/tb_dma_rd_engine.sv - scoreboard bench for dma_rd_engine with an in-order memory model
// Expected addresses/lines are queued at go; negedge monitors pop and compare.
module tb_dma_rd_engine;
  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dma_rd_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dma_rd_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic          go_r = 1'b0;
  logic [AW-1:0] addr_r = '0;
  logic [AW:0]   size_r = '0;
  logic          af_r = 1'b0;
  logic          rspv_r = 1'b0;
  logic [DW-1:0] rspd_r = '0;
  logic          stale_v = 1'b0;
  logic [DW-1:0] stale_d = 32'hDEAD_BEEF;
  logic          rd_r = 1'b0;

  assign bus.go                  = go_r;
  assign bus.start_addr          = addr_r;
  assign bus.size                = size_r;
  assign bus.mem_req_almost_full = af_r;
  assign bus.mem_rsp_valid       = rspv_r | stale_v;
  assign bus.mem_rsp_data        = stale_v ? stale_d : rspd_r;
  assign bus.rd_en               = rd_r;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int req_seen = 0;
  int rsp_sent = 0;
  int first_req_cyc = 0;
  int last_req_cyc  = 0;
  logic af_prev = 1'b0;
  bit   rd_rand = 1'b0;
  bit   rd_fixed = 1'b0;
  bit   lat_rand = 1'b0;
  int   af_mode = 0;

  logic [AW-1:0] exp_addr [$];
  logic [DW-1:0] exp_data [$];
  logic [AW-1:0] pend [$];

  function automatic logic [DW-1:0] line_of(input logic [AW-1:0] a);
    return {a, 8'h3C, a ^ 12'hA5A};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Request and pop monitor
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (bus.mem_req_valid) begin
        if (req_seen == 0) first_req_cyc = cyc;
        last_req_cyc = cyc;
        req_seen++;
        pend.push_back(bus.mem_req_addr);
        check("req_after_almost_full", 64'(af_prev), 64'd0);
        check("req_expected", 64'(exp_addr.size() != 0), 64'd1);
        if (exp_addr.size() != 0) check("req_addr", 64'(bus.mem_req_addr), 64'(exp_addr.pop_front()));
      end
      if (bus.rd_en && !bus.empty) begin
        check("rd_expected", 64'(exp_data.size() != 0), 64'd1);
        if (exp_data.size() != 0) check("rd_data", 64'(bus.rd_data), 64'(exp_data.pop_front()));
      end
    end
    af_prev = bus.mem_req_almost_full;
  end

  // In-order memory: answers each observed request one or more cycles later
  initial forever begin
    @(posedge clk);
    #2;
    if (!rst) begin
      pend.delete();
      rspv_r = 1'b0;
    end else if (pend.size() != 0 && (!lat_rand || $urandom_range(0, 2) != 0)) begin
      rspd_r = line_of(pend.pop_front());
      rspv_r = 1'b1;
      rsp_sent++;
    end else begin
      rspv_r = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    rd_r = rd_rand ? 1'($urandom_range(0, 1)) : rd_fixed;
    case (af_mode)
      0:       af_r = 1'b0;
      1:       af_r = ~af_r;
      default: af_r = ($urandom_range(0, 3) == 0);
    endcase
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [AW-1:0] a, input int n);
    go_r = 1'b1;
    addr_r = a;
    size_r = (AW+1)'(n);
    req_seen = 0;
    rsp_sent = 0;
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(a + AW'(i));
      exp_data.push_back(line_of(a + AW'(i)));
    end
    tick();
    go_r = 1'b0;
  endtask

  task automatic wait_done(input string name, input int n, input int budget);
    int k = 0;
    while (!bus.done && k < budget) begin
      tick();
      k++;
    end
    check({name, "_done"}, 64'(bus.done), 64'd1);
    check({name, "_rsp_count"}, 64'(rsp_sent), 64'(n));
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while ((!bus.empty || exp_data.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    check({name, "_lines_left"}, 64'(exp_data.size()), 64'd0);
    check({name, "_empty"}, 64'(bus.empty), 64'd1);
  endtask

  initial begin
    repeat (3) tick();
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
    check("rst_req_addr", 64'(bus.mem_req_addr), 64'd0);
    check("rst_empty", 64'(bus.empty), 64'd1);
    rst = 1'b1;
    tick();

    // Basic 4-line read, immediate memory, always popping
    rd_fixed = 1'b1;
    start(12'h100, 4);
    wait_done("t1", 4, 100);
    check("t1_req_count", 64'(req_seen), 64'd4);
    check("t1_consecutive", 64'(last_req_cyc - first_req_cyc), 64'd3);
    drain("t1", 50);

    // Zero-length transfer
    start(12'h055, 0);
    check("t2_done_cycle1", 64'(bus.done), 64'd0);
    tick();
    check("t2_done_cycle2", 64'(bus.done), 64'd1);
    repeat (5) tick();
    check("t2_no_requests", 64'(req_seen), 64'd0);
    check("t2_empty", 64'(bus.empty), 64'd1);

    // Credit limit with no draining
    rd_fixed = 1'b0;
    start(12'h200, 16);
    repeat (20) tick();
    check("t3_stall_reqs", 64'(req_seen), 64'd4);
    check("t3_stall_rsps", 64'(rsp_sent), 64'd4);
    check("t3_not_empty", 64'(bus.empty), 64'd0);
    rd_fixed = 1'b1;
    tick();
    rd_fixed = 1'b0;
    repeat (10) tick();
    check("t3_one_more_req", 64'(req_seen), 64'd5);
    rd_fixed = 1'b1;
    wait_done("t3", 16, 300);
    drain("t3", 50);

    // Toggling almost_full with random latency and random pops
    af_mode = 1;
    lat_rand = 1'b1;
    rd_rand = 1'b1;
    start(12'h7FC, 8);
    wait_done("t4", 8, 300);
    check("t4_req_count", 64'(req_seen), 64'd8);
    drain("t4", 300);
    af_mode = 0;
    lat_rand = 1'b0;
    rd_rand = 1'b0;

    // Address wrap
    rd_fixed = 1'b1;
    start(12'hFFE, 4);
    wait_done("t5", 4, 100);
    drain("t5", 50);

    // Reset mid-transfer, stale responses, then a fresh transfer
    rd_fixed = 1'b0;
    start(12'h300, 8);
    begin
      int k = 0;
      while (rsp_sent < 3 && k < 50) begin
        tick();
        k++;
      end
    end
    check("t6_three_rsps", 64'(rsp_sent >= 3), 64'd1);
    rst = 1'b0;
    exp_addr.delete();
    exp_data.delete();
    tick();
    tick();
    check("t6_rst_empty", 64'(bus.empty), 64'd1);
    check("t6_rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
    rst = 1'b1;
    req_seen = 0;
    tick();
    stale_v = 1'b1;
    tick();
    tick();
    stale_v = 1'b0;
    tick();
    check("t6_stale_empty", 64'(bus.empty), 64'd1);
    check("t6_stale_done", 64'(bus.done), 64'd0);
    check("t6_idle_no_reqs", 64'(req_seen), 64'd0);
    rd_fixed = 1'b1;
    start(12'h0A0, 2);
    wait_done("t6", 2, 100);
    check("t6_req_count", 64'(req_seen), 64'd2);
    drain("t6", 50);

    // Randomized transfers
    rd_rand = 1'b1;
    lat_rand = 1'b1;
    af_mode = 2;
    for (int t = 0; t < 8; t++) begin
      logic [AW-1:0] a;
      int n;
      a = AW'($urandom);
      n = int'($urandom_range(1, 20));
      start(a, n);
      wait_done("rand", n, 600);
      check("rand_req_count", 64'(req_seen), 64'(n));
      drain("rand", 400);
    end

    check("final_addr_queue", 64'(exp_addr.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
